miriscv_rvfi_sched: RTL and testbench

MIRISCV_RVFI_SCHED -- requirements
Module: miriscv_rvfi_sched

---
 rtl/miriscv_rvfi_sched.sv | 168 ++++++++++++++++
 tb/tb_miriscv_rvfi_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_rvfi_sched.sv
// rtl/miriscv_rvfi_sched.sv - merges two RVFI retirement streams into rvfi_order sequence
// Optional watchdog compiled in with MIRISCV_RVFI_SCHED_TIMEOUT_EN.
module miriscv_rvfi_sched #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [63:0]       in0_order,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [63:0]       in1_order,
    input  logic [DATA_W-1:0] in1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_order,
    output logic [DATA_W-1:0] out_data,
    output logic              err_gap,
    output logic              err_dup,
    output logic              err_timeout
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]             in_valid;
    logic [1:0][63:0]       in_order;
    logic [1:0][DATA_W-1:0] in_data;
    logic [1:0][63:0]       head_order;
    logic [1:0][DATA_W-1:0] head_data;
    logic [1:0]             push, pop, empty, full, match;

    logic [63:0]       exp_order_q, exp_order_d;
    logic              out_valid_q, out_valid_d;
    logic [63:0]       out_order_q, out_order_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              err_gap_q, err_gap_d;
    logic              err_dup_q, err_dup_d;
    logic              out_free, load, gap_now;

    assign in_valid = {in1_valid, in0_valid};
    assign in_order = {in1_order, in0_order};
    assign in_data  = {in1_data, in0_data};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [63:0]       ord_mem_q [DEPTH];
        logic [DATA_W-1:0] dat_mem_q [DEPTH];
        logic [PW-1:0]     wr_ptr_q, rd_ptr_q;

        // Extra MSB distinguishes full from empty when the index bits coincide.
        assign empty[g] = (wr_ptr_q == rd_ptr_q);
        assign full[g]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign push[g]  = in_valid[g] && !full[g];
        assign head_order[g] = ord_mem_q[rd_ptr_q[AW-1:0]];
        assign head_data[g]  = dat_mem_q[rd_ptr_q[AW-1:0]];
        assign match[g] = !empty[g] && (head_order[g] == exp_order_q);

        always_ff @(posedge clk) begin
            if (push[g]) begin
                ord_mem_q[wr_ptr_q[AW-1:0]] <= in_order[g];
                dat_mem_q[wr_ptr_q[AW-1:0]] <= in_data[g];
            end
        end

        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push[g]) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop[g])  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    assign in0_ready = !full[0];
    assign in1_ready = !full[1];

    // A detected gap freezes the scheduler until reset.
    assign out_free = !out_valid_q || out_ready;
    assign load     = out_free && (|match) && !err_gap_q;
    assign gap_now  = !empty[0] && !empty[1] && !(|match);
    assign pop      = load ? match : 2'b00;

    always_comb begin
        out_valid_d = out_valid_q;
        out_order_d = out_order_q;
        out_data_d  = out_data_q;
        exp_order_d = exp_order_q;
        err_gap_d   = err_gap_q | gap_now;
        err_dup_d   = err_dup_q | (load && (&match));
        if (load) begin
            out_valid_d = 1'b1;
            exp_order_d = exp_order_q + 64'd1;
            if (match[0]) begin
                out_order_d = head_order[0];
                out_data_d  = head_data[0];
            end else begin
                out_order_d = head_order[1];
                out_data_d  = head_data[1];
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            exp_order_q <= '0;
            out_valid_q <= 1'b0;
            out_order_q <= '0;
            out_data_q  <= '0;
            err_gap_q   <= 1'b0;
            err_dup_q   <= 1'b0;
        end else begin
            exp_order_q <= exp_order_d;
            out_valid_q <= out_valid_d;
            out_order_q <= out_order_d;
            out_data_q  <= out_data_d;
            err_gap_q   <= err_gap_d;
            err_dup_q   <= err_dup_d;
        end
    end

`ifdef MIRISCV_RVFI_SCHED_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_timeout_q, err_timeout_d;

    // Counts stalled cycles with work pending; saturates at the limit.
    always_comb begin
        wdog_d = wdog_q;
        if (load) begin
            wdog_d = '0;
        end else if (!(&empty) && (wdog_q != WW'(TIMEOUT))) begin
            wdog_d = wdog_q + {{(WW-1){1'b0}}, 1'b1};
        end
        err_timeout_d = err_timeout_q | (wdog_d == WW'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_order = out_order_q;
    assign out_data  = out_data_q;
    assign err_gap   = err_gap_q;
    assign err_dup   = err_dup_q;

endmodule

// File: tb/tb_miriscv_rvfi_sched.sv
// tb/tb_miriscv_rvfi_sched.sv - scoreboard bench for miriscv_rvfi_sched
module tb_miriscv_rvfi_sched;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic              in0_valid = 1'b0, in1_valid = 1'b0;
    logic              in0_ready, in1_ready;
    logic [63:0]       in0_order = '0, in1_order = '0;
    logic [DATA_W-1:0] in0_data = '0, in1_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [63:0]       out_order;
    logic [DATA_W-1:0] out_data;
    logic              err_gap, err_dup, err_timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [63:0]       order;
        logic [DATA_W-1:0] data;
    } item_t;
    item_t exp_q[$];

    logic              hold_prev = 1'b0;
    logic [63:0]       hold_order;
    logic [DATA_W-1:0] hold_data;

`ifdef MIRISCV_RVFI_SCHED_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    miriscv_rvfi_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clk(clk), .arst(arst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_order(in0_order), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_order(in1_order), .in1_data(in1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order), .out_data(out_data),
        .err_gap(err_gap), .err_dup(err_dup), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pay(input int p, input logic [63:0] o);
        pay = {16'hDA70 + 16'(p), 48'h0, o};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_item(input logic [63:0] o, input int p);
        item_t it;
        it.order = o;
        it.data  = pay(p, o);
        exp_q.push_back(it);
    endtask

    task automatic drive(input logic v0, input logic [63:0] o0, input logic v1, input logic [63:0] o1);
        in0_valid = v0; in0_order = o0; in0_data = pay(0, o0);
        in1_valid = v1; in1_order = o1; in1_data = pay(1, o1);
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        check({name, "_drain_left"}, DATA_W'(exp_q.size()), '0);
    endtask

    // Monitor: scoreboard compare on every handshake, stability while stalled.
    always @(negedge clk) begin
        if (arst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && out_valid) begin
                check("hold_order", DATA_W'(out_order), DATA_W'(hold_order));
                check("hold_data", out_data, hold_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_order", DATA_W'(out_order), '1);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    check("sb_order", DATA_W'(out_order), DATA_W'(it.order));
                    check("sb_data", out_data, it.data);
                end
            end
            hold_prev  = out_valid && !out_ready;
            hold_order = out_order;
            hold_data  = out_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_in0_ready", DATA_W'(in0_ready), 1);
        check("rst_in1_ready", DATA_W'(in1_ready), 1);
        check("rst_out_valid", DATA_W'(out_valid), 0);
        check("rst_errs", DATA_W'({err_gap, err_dup, err_timeout}), 0);

        // Orders 0,1,2 back to back, first push on first edge after reset release
        arst = 1'b0;
        expect_item(0, 0); expect_item(1, 0); expect_item(2, 0);
        drive(1, 0, 0, 0);
        check("lat_cycle1_valid", DATA_W'(out_valid), 0);
        drive(1, 1, 0, 0);
        check("lat_cycle2_valid", DATA_W'(out_valid), 1);
        check("lat_cycle2_order", DATA_W'(out_order), 0);
        drive(1, 2, 0, 0);
        check("seq_cycle3_order", DATA_W'(out_order), 1);
        tick();
        check("seq_cycle4_order", DATA_W'(out_order), 2);
        wait_drain("t1");
        check("t1_errs", DATA_W'({err_gap, err_dup}), 0);

        // Port0 0..: orders 3,5 on port0, 4 on port1 (exp continues at 3)
        expect_item(3, 0); expect_item(4, 1); expect_item(5, 0);
        drive(1, 3, 0, 0);
        drive(1, 5, 0, 0);
        repeat (3) tick();
        drive(0, 0, 1, 4);
        wait_drain("t2");
        check("t2_errs", DATA_W'({err_gap, err_dup}), 0);

        // Back-pressure: DEPTH+1 items, one held in output register
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            expect_item(64'(6 + i), 0);
            drive(1, 64'(6 + i), 0, 0);
        end
        check("bp_in0_ready", DATA_W'(in0_ready), 0);
        check("bp_out_order", DATA_W'(out_order), 6);
        repeat (3) tick();
        check("bp_out_order_later", DATA_W'(out_order), 6);
        check("bp_in0_ready_later", DATA_W'(in0_ready), 0);
        out_ready = 1'b1;
        wait_drain("t3");

        // Duplicate at exp_order 11
        expect_item(11, 0);
        drive(1, 11, 1, 11);
        wait_drain("t4a");
        check("dup_flag", DATA_W'(err_dup), 1);
        expect_item(12, 1);
        drive(0, 0, 1, 12);
        wait_drain("t4b");
        check("dup_sticky", DATA_W'(err_dup), 1);
        check("dup_no_gap", DATA_W'(err_gap), 0);

        // Gap: fresh reset, heads 5 and 7 at exp_order 0
        arst = 1'b1;
        tick();
        arst = 1'b0;
        check("rst2_dup_cleared", DATA_W'(err_dup), 0);
        drive(1, 5, 1, 7);
        repeat (4) tick();
        check("gap_flag", DATA_W'(err_gap), 1);
        check("gap_out_valid", DATA_W'(out_valid), 0);
        @(posedge clk);
        #3 arst = 1'b1;
        #1;
        check("async_rst_errs", DATA_W'({err_gap, err_dup, err_timeout}), 0);
        check("async_rst_readies", DATA_W'({in0_ready, in1_ready}), 3);
        check("async_rst_out_valid", DATA_W'(out_valid), 0);
        tick();
        arst = 1'b0;
        expect_item(0, 0);
        drive(1, 0, 0, 0);
        wait_drain("t5");

        // Lone mismatching head waits without error
        expect_item(1, 1); expect_item(2, 1); expect_item(3, 0);
        drive(1, 3, 0, 0);
        repeat (20) tick();
        check("wait_no_gap", DATA_W'(err_gap), 0);
        check("wait_out_valid", DATA_W'(out_valid), 0);
        check("wait_timeout", DATA_W'(err_timeout), DATA_W'(TO_EXP));
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 2);
        wait_drain("t6");
        check("t6_no_gap", DATA_W'(err_gap), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
